// File: rtl/mont_operand_loader.sv
// Word-serial operand loader and result unloader for the Montgomery multiplier.
// Assembles a, b, m from a word stream, starts the core, and streams the result back.
module mont_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OP_W-1:0]   mont_a,
    output logic [OP_W-1:0]   mont_b,
    output logic [OP_W-1:0]   mont_m,
    output logic              mont_start,
    input  logic [OP_W-1:0]   mont_result,
    input  logic              mont_done,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int NWORDS = OP_W / WORD_W;
    localparam int LC_W   = $clog2(3 * NWORDS);
    localparam int UC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [LC_W-1:0] LC_B    = LC_W'(NWORDS);
    localparam logic [LC_W-1:0] LC_M    = LC_W'(2 * NWORDS);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(3 * NWORDS - 1);
    localparam logic [UC_W-1:0] UC_LAST = UC_W'(NWORDS - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    state_t          state;
    logic [LC_W-1:0] lc;
    logic [UC_W-1:0] uc;
    logic [OP_W-1:0] a_reg;
    logic [OP_W-1:0] b_reg;
    logic [OP_W-1:0] m_reg;
    logic [OP_W-1:0] result;
    logic            start_reg;

    // New words enter at the top so the first word ends up least significant.
    function automatic logic [OP_W-1:0] shift_in(input logic [OP_W-1:0] r,
                                                 input logic [WORD_W-1:0] w);
        return {w, r[OP_W-1:WORD_W]};
    endfunction

    function automatic logic [OP_W-1:0] shift_out(input logic [OP_W-1:0] r);
        return {{WORD_W{1'b0}}, r[OP_W-1:WORD_W]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            lc        <= '0;
            uc        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            m_reg     <= '0;
            result    <= '0;
            start_reg <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (lc < LC_B)
                            a_reg <= shift_in(a_reg, in_word);
                        else if (lc < LC_M)
                            b_reg <= shift_in(b_reg, in_word);
                        else
                            m_reg <= shift_in(m_reg, in_word);
                        if (lc == LC_LAST) begin
                            lc        <= '0;
                            state     <= START;
                            start_reg <= 1'b1;
                        end else begin
                            lc <= lc + 1'b1;
                        end
                    end
                end
                START: begin
                    start_reg <= 1'b0;
                    state     <= WAIT;
                end
                // Done is only honoured here, so a done level present during START is ignored.
                WAIT: begin
                    if (mont_done) begin
                        result <= mont_result;
                        uc     <= '0;
                        state  <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        result <= shift_out(result);
                        if (uc == UC_LAST) begin
                            uc    <= '0;
                            state <= LOAD;
                        end else begin
                            uc <= uc + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == UNLOAD);
    assign out_word   = result[WORD_W-1:0];
    assign mont_start = start_reg;
    assign mont_a     = a_reg;
    assign mont_b     = b_reg;
    assign mont_m     = m_reg;
    assign busy       = !((state == LOAD) && (lc == '0));

endmodule

// File: tb/tb_mont_operand_loader.sv
// Directed bench for mont_operand_loader: load, start, wait, unload, stalls and resets.
module tb_mont_operand_loader;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   in_word;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] mont_a;
    logic [1023:0] mont_b;
    logic [1023:0] mont_m;
    logic          mont_start;
    logic [1023:0] mont_result;
    logic          mont_done;
    logic [31:0]   out_word;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic [1023:0] exp_a;
    logic [1023:0] exp_b;
    logic [1023:0] exp_m;

    mont_operand_loader #(.WORD_W(32), .OP_W(1024)) dut (
        .clk(clk), .reset(reset),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_start(mont_start), .mont_result(mont_result), .mont_done(mont_done),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got[191:0], exp[191:0]);
        end
    endtask

    function automatic logic [31:0] word_val(input int w);
        if (w < 32)      return 32'(w);
        else if (w < 64) return 32'h100 + 32'(w - 32);
        else             return 32'h200 + 32'(w - 64);
    endfunction

    function automatic logic [1023:0] build_result(input logic [31:0] base);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    // Returns at the negedge after the n-th accepted word.
    task automatic load_words(input int n, input bit gaps);
        int  acc = 0;
        int  cyc = 0;
        bit  hs;
        while (acc < n && cyc < 3000) begin
            @(negedge clk);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_word  = in_valid ? word_val(acc) : 32'hDEAD_BEEF;
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) acc++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_val("load_count", 1024'(acc), 1024'(n));
    endtask

    // Called at the START-cycle negedge; done pulses 5 cycles after start.
    task automatic done_pulse(input logic [31:0] base);
        logic [1023:0] a_snap;
        a_snap = mont_a;
        mont_result = build_result(base);
        @(negedge clk);
        check_val("start_one_cycle", 1024'(mont_start), 1024'(0));
        in_valid = 1'b1;
        in_word  = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_val("wait_in_ready", 1024'(in_ready), 1024'(0));
        check_val("wait_out_valid", 1024'(out_valid), 1024'(0));
        check_val("wait_busy", 1024'(busy), 1024'(1));
        @(negedge clk);
        mont_done = 1'b1;
        @(negedge clk);
        mont_done = 1'b0;
        in_valid  = 1'b0;
        check_val("unload_valid", 1024'(out_valid), 1024'(1));
        check_val("wait_ops_held", mont_a, a_snap);
    endtask

    // Called at the first UNLOAD negedge.
    task automatic unload(input logic [31:0] base, input bit stall, input int n);
        for (int k = 0; k < n; k++) begin
            if (stall) begin
                for (int s = 0; s < 3; s++) begin
                    out_ready = 1'b0;
                    check_val("stall_word", 1024'(out_word), 1024'(base + 32'(k)));
                    check_val("stall_valid", 1024'(out_valid), 1024'(1));
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            check_val("out_word", 1024'(out_word), 1024'(base + 32'(k)));
            check_val("unload_in_ready", 1024'(in_ready), 1024'(0));
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (n == 32) begin
            check_val("end_out_valid", 1024'(out_valid), 1024'(0));
            check_val("end_in_ready", 1024'(in_ready), 1024'(1));
            check_val("end_busy", 1024'(busy), 1024'(0));
        end
    endtask

    task automatic txn(input bit gaps, input bit stall, input logic [31:0] base);
        load_words(96, gaps);
        check_val("start_pulse", 1024'(mont_start), 1024'(1));
        check_val("start_in_ready", 1024'(in_ready), 1024'(0));
        check_val("op_a", mont_a, exp_a);
        check_val("op_b", mont_b, exp_b);
        check_val("op_m", mont_m, exp_m);
        done_pulse(base);
        unload(base, stall, 32);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            exp_a[i*32 +: 32] = word_val(i);
            exp_b[i*32 +: 32] = word_val(32 + i);
            exp_m[i*32 +: 32] = word_val(64 + i);
        end
        reset = 1'b1; in_valid = 1'b0; in_word = '0;
        mont_result = '0; mont_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", 1024'(in_ready), 1024'(1));
        check_val("rst_busy", 1024'(busy), 1024'(0));
        check_val("rst_out_valid", 1024'(out_valid), 1024'(0));
        check_val("rst_start", 1024'(mont_start), 1024'(0));
        check_val("rst_a", mont_a, '0);

        // No stalls, with spot checks on the operand layout
        load_words(96, 1'b0);
        check_val("start_pulse", 1024'(mont_start), 1024'(1));
        check_val("a_low", 1024'(mont_a[31:0]), 1024'(0));
        check_val("a_high", 1024'(mont_a[1023:992]), 1024'(31));
        check_val("m_w1", 1024'(mont_m[63:32]), 1024'(32'h201));
        check_val("op_b", mont_b, exp_b);
        done_pulse(32'hA000);
        unload(32'hA000, 1'b0, 32);

        // Input gaps and output backpressure
        txn(1'b1, 1'b1, 32'h5000);

        // Done held high throughout: captured once, in the first WAIT cycle
        mont_result = build_result(32'hB000);
        mont_done = 1'b1;
        load_words(96, 1'b0);
        check_val("held_start", 1024'(mont_start), 1024'(1));
        @(negedge clk);
        check_val("held_wait_cycle", 1024'(out_valid), 1024'(0));
        @(negedge clk);
        check_val("held_unload", 1024'(out_valid), 1024'(1));
        mont_result = build_result(32'hC000);
        unload(32'hB000, 1'b0, 32);
        mont_done = 1'b0;
        txn(1'b0, 1'b0, 32'h7000);

        // Asynchronous reset mid-load
        load_words(40, 1'b0);
        check_val("midload_busy", 1024'(busy), 1024'(1));
        #2 reset = 1'b1;
        #1;
        check_val("rst_load_busy", 1024'(busy), 1024'(0));
        check_val("rst_load_a", mont_a, '0);
        check_val("rst_load_b", mont_b, '0);
        check_val("rst_load_ov", 1024'(out_valid), 1024'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_load_ready", 1024'(in_ready), 1024'(1));
        txn(1'b0, 1'b0, 32'hD000);

        // Asynchronous reset mid-unload
        load_words(96, 1'b0);
        done_pulse(32'hE000);
        unload(32'hE000, 1'b0, 10);
        #2 reset = 1'b1;
        #1;
        check_val("rst_unl_ov", 1024'(out_valid), 1024'(0));
        check_val("rst_unl_busy", 1024'(busy), 1024'(0));
        check_val("rst_unl_word", 1024'(out_word), 1024'(0));
        check_val("rst_unl_a", mont_a, '0);
        @(negedge clk);
        reset = 1'b0;
        txn(1'b1, 1'b1, 32'hF000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
